// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter register and next-PC selection. Chooses between the
//   exception vector, JR/JALR target, J/JAL target, conditional branch target
//   and the sequential PC+4. A redirect that arrives while fetch is stalled is
//   parked in a one-entry buffer and applied on the first unstalled edge.
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous reset, active high
//   stall             hold PC this cycle (exceptions still redirect)
//   branch_taken      conditional branch resolved taken
//   branch_base       PC+4 of the branch instruction
//   branch_offset     word-aligned, sign-extended branch offset
//   jump              J/JAL redirect
//   jump_index        26-bit instr_index field
//   jr                register-indirect redirect
//   jr_target         register value for JR/JALR
//   exception         exception redirect request
//   pc                current fetch address (registered)
//   pc_plus4          pc + 4 (combinational from pc only)
//   redirect_pending  a buffered redirect is waiting (registered)
//   misaligned        one-cycle pulse: selected JR target had nonzero [1:0]
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_base,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exception,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect_pending,
  output logic        misaligned
);

  logic [31:0] pc_r;
  logic        pend_valid_r;
  logic [31:0] pend_tgt_r;
  logic        misaligned_r;

  logic        redirect_s;
  logic [31:0] new_tgt_s;
  logic        misalign_s;
  logic [31:0] pc_nxt_s;
  logic        pend_valid_nxt_s;
  logic [31:0] pend_tgt_nxt_s;

  // Target selection in priority order: exception > jr > jump > branch.
  always_comb begin
    redirect_s = exception | jr | jump | branch_taken;
    new_tgt_s  = 32'h0000_0000;
    misalign_s = 1'b0;
    if (exception) begin
      new_tgt_s = EXC_VECTOR;
    end else if (jr) begin
      // Low bits are dropped from the target but still reported.
      new_tgt_s  = {jr_target[31:2], 2'b00};
      misalign_s = (jr_target[1:0] != 2'b00);
    end else if (jump) begin
      new_tgt_s = {branch_base[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      new_tgt_s = branch_base + branch_offset;
    end else begin
      new_tgt_s = 32'h0000_0000;
    end
  end

  // Next PC and pending-buffer update; exceptions bypass the stall.
  always_comb begin
    pc_nxt_s         = pc_r;
    pend_valid_nxt_s = pend_valid_r;
    pend_tgt_nxt_s   = pend_tgt_r;
    if (exception) begin
      pc_nxt_s         = EXC_VECTOR;
      pend_valid_nxt_s = 1'b0;
    end else if (redirect_s) begin
      if (stall) begin
        // Newest redirect overwrites any older buffered one.
        pend_valid_nxt_s = 1'b1;
        pend_tgt_nxt_s   = new_tgt_s;
      end else begin
        // A live redirect overrides a buffered one.
        pc_nxt_s         = new_tgt_s;
        pend_valid_nxt_s = 1'b0;
      end
    end else if (stall) begin
      pc_nxt_s = pc_r;
    end else if (pend_valid_r) begin
      pc_nxt_s         = pend_tgt_r;
      pend_valid_nxt_s = 1'b0;
    end else begin
      pc_nxt_s = pc_r + 32'd4;
    end
  end

  // State registers for PC, pending buffer and misaligned pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r         <= RESET_PC;
      pend_valid_r <= 1'b0;
      pend_tgt_r   <= 32'h0000_0000;
      misaligned_r <= 1'b0;
    end else begin
      pc_r         <= pc_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      pend_tgt_r   <= pend_tgt_nxt_s;
      misaligned_r <= misalign_s;
    end
  end

  assign pc               = pc_r;
  assign pc_plus4         = pc_r + 32'd4;
  assign redirect_pending = pend_valid_r;
  assign misaligned       = misaligned_r;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_base;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        exception;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect_pending;
  logic        misaligned;

  int n_cmp;
  int n_fail;

  pc_sequencer #(
    .RESET_PC  (32'h0000_0000),
    .EXC_VECTOR(32'h0000_0080)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_base     (branch_base),
    .branch_offset   (branch_offset),
    .jump            (jump),
    .jump_index      (jump_index),
    .jr              (jr),
    .jr_target       (jr_target),
    .exception       (exception),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .redirect_pending(redirect_pending),
    .misaligned      (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic        br;
    logic [31:0] base;
    logic [31:0] off;
    logic        jmp;
    logic [25:0] idx;
    logic        jrv;
    logic [31:0] jrt;
    logic        exc;
    logic [31:0] exp_pc;
    logic        exp_pend;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; branch_taken = 1'b0; branch_base = 32'h0; branch_offset = 32'h0;
    jump = 1'b0; jump_index = 26'h0; jr = 1'b0; jr_target = 32'h0; exception = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    stall = v.stall; branch_taken = v.br; branch_base = v.base; branch_offset = v.off;
    jump = v.jmp; jump_index = v.idx; jr = v.jrv; jr_target = v.jrt; exception = v.exc;
  endtask

  // One edge, then check outputs 1 time unit later.
  task automatic step_check(input string nm, input logic [31:0] epc,
                            input logic epend, input logic emis);
    @(posedge clk);
    #1;
    chk({nm, ".pc"}, pc, epc);
    chk({nm, ".pc_plus4"}, pc_plus4, epc + 32'd4);
    chk_bit({nm, ".pending"}, redirect_pending, epend);
    chk_bit({nm, ".misaligned"}, misaligned, emis);
  endtask

  function automatic vec_t mk(input string nm, input logic st, input logic br,
                              input logic [31:0] base, input logic [31:0] off,
                              input logic jm, input logic [25:0] idx,
                              input logic jv, input logic [31:0] jt, input logic ex,
                              input logic [31:0] epc, input logic ep, input logic em);
    vec_t v;
    v.name = nm; v.stall = st; v.br = br; v.base = base; v.off = off;
    v.jmp = jm; v.idx = idx; v.jrv = jv; v.jrt = jt; v.exc = ex;
    v.exp_pc = epc; v.exp_pend = ep; v.exp_mis = em;
    return v;
  endfunction

  // Reference model state: pending buffer kept as a queue of at most one target.
  logic [31:0] m_pc;
  logic [31:0] m_pend_q[$];
  logic        m_mis;

  task automatic model_edge(input logic st, input logic br, input logic [31:0] base,
                            input logic [31:0] off, input logic jm, input logic [25:0] idx,
                            input logic jv, input logic [31:0] jt, input logic ex);
    logic [31:0] tgt;
    bit          redir;
    redir = ex || jv || jm || br;
    if (ex)      tgt = 32'h80;
    else if (jv) tgt = jt & 32'hFFFF_FFFC;
    else if (jm) tgt = (base & 32'hF000_0000) | (32'(idx) * 32'd4);
    else         tgt = base + off;
    m_mis = jv && !ex && (jt % 32'd4 != 32'd0);
    if (ex) begin
      m_pc = 32'h80;
      m_pend_q.delete();
    end else if (redir && st) begin
      m_pend_q.delete();
      m_pend_q.push_back(tgt);
    end else if (redir) begin
      m_pc = tgt;
      m_pend_q.delete();
    end else if (st) begin
      m_pc = m_pc;
    end else if (m_pend_q.size() != 0) begin
      m_pc = m_pend_q.pop_front();
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("reset.pc", pc, 32'h0);
    chk_bit("reset.pending", redirect_pending, 1'b0);
    chk_bit("reset.misaligned", misaligned, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reach pc=0x40 via a jump, then reset asynchronously mid-cycle.
    jump = 1'b1; jump_index = 26'h10;
    step_check("to40", 32'h40, 1'b0, 1'b0);
    idle_inputs();
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst.pc", pc, 32'h0);
    chk_bit("async_rst.pending", redirect_pending, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step_check("seq1", 32'h4, 1'b0, 1'b0);
    step_check("seq2", 32'h8, 1'b0, 1'b0);
    step_check("seq3", 32'hC, 1'b0, 1'b0);

    // Directed vector table, continuing from pc=0xC.
    vecs.push_back(mk("jr100",   0,0,32'h0,32'h0,          0,26'h0,  1,32'h100,0,        32'h100,0,0));
    vecs.push_back(mk("branch",  0,1,32'h104,32'hFFFF_FFF0,0,26'h0,  0,32'h0,0,          32'hF4,0,0));
    vecs.push_back(mk("seqF8",   0,0,32'h0,32'h0,          0,26'h0,  0,32'h0,0,          32'hF8,0,0));
    vecs.push_back(mk("jmp_br",  0,1,32'h8000_0004,32'h0,  1,26'h10, 0,32'h0,0,          32'h8000_0040,0,0));
    vecs.push_back(mk("jr_win",  0,1,32'h8000_0004,32'h0,  1,26'h10, 1,32'h1234_5678,0,  32'h1234_5678,0,0));
    vecs.push_back(mk("stl_br",  1,1,32'h1F0,32'h10,       0,26'h0,  0,32'h0,0,          32'h1234_5678,1,0));
    vecs.push_back(mk("stl_jmp", 1,0,32'h0,32'h0,          1,26'hC0, 0,32'h0,0,          32'h1234_5678,1,0));
    vecs.push_back(mk("stl_nop", 1,0,32'h0,32'h0,          0,26'h0,  0,32'h0,0,          32'h1234_5678,1,0));
    vecs.push_back(mk("release", 0,0,32'h0,32'h0,          0,26'h0,  0,32'h0,0,          32'h300,0,0));
    vecs.push_back(mk("stl_br2", 1,1,32'h400,32'h0,        0,26'h0,  0,32'h0,0,          32'h300,1,0));
    vecs.push_back(mk("stl_exc", 1,0,32'h0,32'h0,          0,26'h0,  0,32'h0,1,          32'h80,0,0));
    vecs.push_back(mk("seq84",   0,0,32'h0,32'h0,          0,26'h0,  0,32'h0,0,          32'h84,0,0));
    vecs.push_back(mk("jr_mis",  0,0,32'h0,32'h0,          0,26'h0,  1,32'h1003,0,       32'h1000,0,1));
    vecs.push_back(mk("mis_clr", 0,0,32'h0,32'h0,          0,26'h0,  0,32'h0,0,          32'h1004,0,0));
    vecs.push_back(mk("stl_jrm", 1,0,32'h0,32'h0,          0,26'h0,  1,32'h2002,0,       32'h1004,1,1));
    vecs.push_back(mk("exc_jr",  0,0,32'h0,32'h0,          0,26'h0,  1,32'h3,1,          32'h80,0,0));
    vecs.push_back(mk("jr_top",  0,0,32'h0,32'h0,          0,26'h0,  1,32'hFFFF_FFFC,0,  32'hFFFF_FFFC,0,0));
    vecs.push_back(mk("wrap",    0,0,32'h0,32'h0,          0,26'h0,  0,32'h0,0,          32'h0,0,0));
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      step_check(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_pend, vecs[i].exp_mis);
    end

    // Randomized phase against the reference model, starting at pc=0, empty buffer.
    m_pc = 32'h0;
    m_pend_q.delete();
    m_mis = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      stall         = ($urandom_range(2) == 0);
      branch_taken  = ($urandom_range(3) == 0);
      branch_base   = $urandom;
      branch_offset = $urandom;
      jump          = ($urandom_range(5) == 0);
      jump_index    = 26'($urandom);
      jr            = ($urandom_range(6) == 0);
      jr_target     = $urandom;
      exception     = ($urandom_range(15) == 0);
      model_edge(stall, branch_taken, branch_base, branch_offset, jump, jump_index,
                 jr, jr_target, exception);
      step_check("rand", m_pc, (m_pend_q.size() != 0), m_mis);
      if (n_fail > 20) break;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter register and next-PC selection stage of the CPU.
- Sits directly downstream of the immediate shifter. It consumes the word-aligned branch offset (sign-extended immediate << 2) and adds it to the branch base to form the branch target.
- Also handles J/JAL, JR/JALR and exception redirects, pipeline stalls, and a one-entry buffer for a redirect that arrives while the fetch stage is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, PC value loaded on an exception.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active high
- stall  input  1  hold PC this cycle
- branch_taken  input  1  conditional branch resolved taken
- branch_base  input  32  PC+4 of the branch instruction
- branch_offset  input  32  shifted immediate from the shifter stage
- jump  input  1  J/JAL redirect
- jump_index  input  26  instr_index field
- jr  input  1  register-indirect redirect
- jr_target  input  32  register value for JR/JALR
- exception  input  1  exception redirect request
- pc  output  32  current fetch address (registered)
- pc_plus4  output  32  pc + 4, combinational from pc
- redirect_pending  output  1  a buffered redirect is waiting (registered)
- misaligned  output  1  JR target had nonzero [1:0]; 1-cycle registered pulse

Behaviour:
- Reset (async, any time): pc=RESET_PC, pending buffer cleared, redirect_pending=0, misaligned=0. Deassertion takes effect at the next rising edge.
- Target arithmetic, all 32-bit and modulo 2^32 (no overflow detection):
  - branch target = branch_base + branch_offset.
  - jump target = {branch_base[31:28], jump_index, 2'b00}.
  - jr target = {jr_target[31:2], 2'b00}.
- Request priority within a cycle: exception > jr > jump > branch_taken > sequential. Exactly one target, new_tgt, is selected. "Redirect" = any of exception/jr/jump/branch_taken asserted.
- Per-edge update, with stall=0:
  - exception: pc<=EXC_VECTOR; pending cleared.
  - other redirect: pc<=new_tgt; pending cleared. A live redirect overrides any buffered one.
  - no redirect, pending set: pc<=pending target; pending cleared.
  - otherwise: pc<=pc+4. Wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- Per-edge update, with stall=1:
  - exception: pc<=EXC_VECTOR; pending cleared. Exception is never blocked by stall.
  - other redirect: pc held; pending<=new_tgt; redirect_pending<=1. Newest redirect overwrites an older buffered one.
  - no redirect: pc and pending held.
- Latency:
  - A redirect with stall=0 is visible on pc one cycle later.
  - A buffered redirect is visible one cycle after the first edge with stall=0.
- misaligned:
  - Set for exactly one cycle after an edge where jr was the selected request and jr_target[1:0]!=0. This applies whether the redirect was applied or buffered.
  - Cleared on every other edge.
  - Not set when exception outranks jr.
- pc[1:0] is always 2'b00 provided RESET_PC and EXC_VECTOR are word-aligned.
- No combinational path from redirect inputs to pc. pc_plus4 depends only on pc.

Test Plan:
- Reset/sequential: assert rst mid-run with pc=0x0000_0040 -> pc=0x0 immediately. Release and run 3 edges -> pc 0x4, 0x8, 0xC.
- Branch: pc=0x100, branch_taken=1, branch_base=0x104, branch_offset=0xFFFF_FFF0 (imm -4 << 2) -> next pc=0x0000_00F4. Then sequential 0xF8.
- Priority: jump=1, jump_index=0x0000010, branch_taken=1, branch_base=0x8000_0004 -> pc=0x8000_0040. Adding jr=1, jr_target=0x1234_5678 -> pc=0x1234_5678, misaligned=0.
- Stall buffering: stall=1 for 3 cycles, branch_taken pulsed on the first cycle with target 0x200, then jump to 0x300 on the second -> pc held, redirect_pending=1 holding 0x300. Release stall with no redirect -> pc=0x300, redirect_pending=0.
- Exception during stall with pending set: exception=1 -> pc=0x80, redirect_pending=0. misaligned case: jr_target=0x0000_1003 -> pc=0x1000, misaligned high for 1 cycle.
- Wrap: force pc to 0xFFFF_FFFC, run 1 edge with no redirect -> pc=0x0000_0000.
